// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared execute-stage constants and divider state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } div_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/bit_Subtractor.sv
`default_nettype none
// ============================================================================
// Module      : bit_Subtractor
// Description : Unsigned subtractor; borrow is set iff minuend < subtrahend.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_Subtractor #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    logic [WIDTH:0] w_wide;

    // One extra bit captures the borrow out of the MSB.
    assign w_wide   = {1'b0, i_minuend} - {1'b0, i_subtrahend};
    assign o_diff   = w_wide[WIDTH-1:0];
    assign o_borrow = w_wide[WIDTH];

endmodule : bit_Subtractor
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Restoring radix-2 divider, one quotient bit per clock, for
//               DIV/DIVU/REM/REMU with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero
);

    localparam int                c_CNT_W    = $clog2(XLEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(XLEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

    div_state_t         r_state;
    div_state_t         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]    r_r;
    logic [XLEN-1:0]    r_q;
    logic [XLEN-1:0]    r_dvs;
    logic               r_qneg;
    logic               r_rneg;
    logic [XLEN-1:0]    r_quot;
    logic [XLEN-1:0]    r_rem;
    logic               r_dbz;

    logic [XLEN-1:0]    w_abs_dvd;
    logic [XLEN-1:0]    w_abs_dvs;
    logic               w_dvs_zero;
    logic               w_ovf;
    logic [XLEN-1:0]    w_r_shift;
    logic [XLEN-1:0]    w_diff;
    logic               w_borrow;
    logic               w_accept;
    logic [XLEN-1:0]    w_r_next;
    logic [XLEN-1:0]    w_q_next;

    assign w_abs_dvd  = (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
    assign w_abs_dvs  = (signed_op && divisor[XLEN-1])  ? -divisor  : divisor;
    assign w_dvs_zero = (divisor == '0);

    // {ovf, R', Q'} = {R, Q} << 1; ovf is the 65th remainder bit for huge divisors.
    assign w_ovf     = r_r[XLEN-1];
    assign w_r_shift = {r_r[XLEN-2:0], r_q[XLEN-1]};

    bit_Subtractor #(
        .WIDTH (XLEN)
    ) u_sub (
        .i_minuend    (w_r_shift),
        .i_subtrahend (r_dvs),
        .o_diff       (w_diff),
        .o_borrow     (w_borrow)
    );

    assign w_accept = w_ovf | ~w_borrow;
    assign w_r_next = w_accept ? w_diff : w_r_shift;
    assign w_q_next = {r_q[XLEN-2:0], w_accept};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = w_dvs_zero ? ST_DONE : ST_RUN;
            ST_RUN:  if (r_cnt == c_CNT_LAST) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_r    <= '0;
            r_q    <= '0;
            r_dvs  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_dvs  <= w_abs_dvs;
            r_q    <= w_abs_dvd;
            r_r    <= '0;
            r_cnt  <= c_CNT_LOAD;
            r_qneg <= signed_op & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_rneg <= signed_op & dividend[XLEN-1];
            if (w_dvs_zero) begin
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == ST_RUN) begin
            r_r   <= w_r_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt - c_CNT_LAST;
            if (r_cnt == c_CNT_LAST) begin
                r_quot <= r_qneg ? -w_q_next : w_q_next;
                r_rem  <= r_rneg ? -w_r_next : w_r_next;
                r_dbz  <= 1'b0;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule : seq_divider
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle 64-bit integer divider for the execute stage; directly downstream consumer of the team's 64-bit subtractor.
- Runs one restoring-division step per clock. Each step uses the subtractor's difference and borrow to decide the quotient bit.
- Serves RISC-V DIV/DIVU/REM/REMU. The execute stage drives it with a start/busy/done handshake.

Parameters:
- XLEN, 64, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- signed_op  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start
- dividend  in  XLEN  sampled with start
- divisor  in  XLEN  sampled with start
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; results valid from this cycle
- quotient  out  XLEN  result; held until next accepted start
- remainder  out  XLEN  result; held until next accepted start
- div_by_zero  out  1  set with done when divisor==0; held like results

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0. Reset overrides everything, including an operation in progress; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE + start:
  - Latch |dividend| and |divisor| (two's-complement negate when signed_op and the MSB is set).
  - Latch the result signs: q_neg = signed_op & (dividend[63] ^ divisor[63]); r_neg = signed_op & dividend[63].
  - Clear the partial remainder R and load Q with |dividend|.
  - Load counter=XLEN and go to RUN.
  - If divisor==0, skip RUN and go straight to DONE with quotient=all-ones, remainder=dividend (raw, unmodified), div_by_zero=1.
- RUN step, once per cycle:
  - {ovf, R', Q'} = {R, Q} << 1.
  - The subtractor computes R' - |divisor|.
  - Accept when ovf=1 or borrow=0. On accept, R = difference and Q'[0]=1; otherwise R = R' and Q'[0]=0.
  - counter decrements by 1 each cycle.
  - The ovf term covers divisors >= 2^63, where the shifted remainder needs 65 bits.
- Leaving RUN: on the cycle counter reaches 1, the step completes and state goes to DONE. In that same transition:
  - quotient = q_neg ? -Q : Q
  - remainder = r_neg ? -R : R
  - div_by_zero = 0
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - Normal: start sampled at edge t; RUN occupies cycles t+1 … t+XLEN; done is high during cycle t+XLEN+1.
  - Divide-by-zero: done is high during cycle t+1.
- start while busy=1 (RUN or DONE) is ignored; operands are not resampled. Back-to-back starts are accepted earliest in the cycle after done.
- Signed overflow (-2^63 / -1) falls out of the datapath with no special case: quotient=0x8000_0000_0000_0000, remainder=0.
- Output register values change only on reset, on an accepted divide-by-zero start, or on the RUN→DONE transition.
- All arithmetic is modulo 2^XLEN; negation is bitwise complement +1.

Decomposition:
- Shared package riscv_pkg:
  - XLEN constant.
  - Divider state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module: exactly one instance of the existing 64-bit subtractor, bit_Subtractor. Its borrow output is 1 iff the minuend < subtrahend (unsigned).
- Operand and result negation is inline logic, not additional instances.

Test Plan:
- Unsigned 100 / 7 → quotient=14, remainder=2, div_by_zero=0; done high exactly at cycle t+65; busy high cycles t+1 … t+65.
- Signed -7 / 2 → quotient=0xFFFF_FFFF_FFFF_FFFD (-3), remainder=0xFFFF_FFFF_FFFF_FFFF (-1). Also signed 7 / -2 → quotient=-3, remainder=1.
- Divide by zero, unsigned 5 / 0 and signed -5 / 0 → quotient=all-ones, remainder=5 and -5 respectively, div_by_zero=1, done at cycle t+1.
- Overflow and large divisor:
  - Signed 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → quotient=0x8000_0000_0000_0000, remainder=0.
  - Unsigned 0xFFFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0001 → quotient=1, remainder=0x7FFF_FFFF_FFFF_FFFE.
- Start 1000 / 3, pulse start with 9 / 4 at cycle t+10 → second request ignored; results are 333 and 1, done at t+65; a new start the cycle after done is accepted.
- Start 1000 / 3, assert rst at cycle t+30 → next cycle busy=0, done=0, outputs all zero, no done pulse follows. Then start 9 / 4 → quotient=2, remainder=1 after 65 cycles.
